vga_timing_param: RTL and testbench
===================================

Name: vga_timing_param

Overview:
Parametrised VGA timing generator; replaces the fixed 1024x768 timing block at the head of the video pipeline.
- Any resolution is set via porch/sync/active parameters.
- Adds a pixel clock-enable, selectable sync polarity, display-enable and frame/line strobes, and a frame counter.
- Drives the background, sprite and overlay stages with coherent, fully registered counters and sync signals.

Parameters:
H_ACTIVE, 1024, visible pixels per line
H_FP, 24, horizontal front porch (pixels)
H_SYNC, 136, hsync width (pixels)
H_BP, 160, horizontal back porch (pixels)
V_ACTIVE, 768, visible lines per frame
V_FP, 3, vertical front porch (lines)
V_SYNC, 6, vsync width (lines)
V_BP, 29, vertical back porch (lines)
HSYNC_POL, 1, 1 = hsync active-high, 0 = active-low
VSYNC_POL, 1, 1 = vsync active-high, 0 = active-low
CNT_W, 11, width of hcount/vcount
FRAME_W, 8, width of frame_cnt

Ports:
clk  in  1  system clock (65 MHz for XGA defaults)
rst_n  in  1  synchronous active-low reset
pix_ce  in  1  pixel enable; counters advance only on clk edges with pix_ce=1
hcount  out  CNT_W  horizontal position, 0..H_TOTAL-1
vcount  out  CNT_W  vertical position, 0..V_TOTAL-1
hblnk  out  1  high when hcount >= H_ACTIVE
vblnk  out  1  high when vcount >= V_ACTIVE
hsync  out  1  asserted (per HSYNC_POL) for hcount in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC)
vsync  out  1  asserted (per VSYNC_POL) for vcount in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC)
de  out  1  !hblnk && !vblnk
line_start  out  1  one-clk strobe when hcount wraps to 0
frame_start  out  1  one-clk strobe when (hcount,vcount) wraps to (0,0)
frame_cnt  out  FRAME_W  completed-frame counter, modulo 2^FRAME_W

Behaviour:
Totals:
- H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP.
- V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP.
- Derived localparams.
Elaboration checks (error if violated):
- H_TOTAL <= 2^CNT_W and V_TOTAL <= 2^CNT_W.
- All porch/sync/active parameters >= 1.
Reset (rst_n=0 at a clk edge, regardless of pix_ce):
- hcount=0, vcount=0, frame_cnt=0.
- hblnk=0, vblnk=0, de=1.
- hsync and vsync at inactive level (= !POL).
- line_start=0, frame_start=0.
- Reset mid-line or mid-frame aborts immediately; no strobe is produced.
Counting (on clk edge with rst_n=1 and pix_ce=1):
- If hcount < H_TOTAL-1: hcount+1, vcount holds.
- If hcount == H_TOTAL-1: hcount=0.
  - vcount+1 if vcount < V_TOTAL-1, else vcount=0.
- The last line of the frame is full length. vcount never wraps before hcount reaches H_TOTAL-1.
- pix_ce=0: all counters and level outputs hold; strobes drop to 0.
Output timing:
- All outputs are registered. They are decoded from next-state counter values, so in every clk cycle hblnk/vblnk/hsync/vsync/de match that cycle's hcount/vcount exactly (zero skew, no glitches).
Strobes:
- line_start=1 for exactly one clk, in the cycle where hcount first shows 0 after a wrap.
- frame_start=1 in the same cycle as line_start when vcount also wrapped to 0.
- Both strobes are 0 in all other cycles, including while pix_ce holds them at 0.
- No strobe is issued for the (0,0) state entered by reset.
frame_cnt:
- Increments in the same clk as frame_start.
- Wraps 2^FRAME_W-1 -> 0.
Out-of-range counts (cannot occur after reset; defensive only):
- hcount >= H_TOTAL behaves as H_TOTAL-1.
- vcount >= V_TOTAL behaves as V_TOTAL-1.

Decomposition:
Shared package vga_pkg holds:
- Mode constants for XGA 1024x768 (defaults above) and SVGA 800x600 (40/128/88, 1/4/23, active-high syncs).
- A function computing H_TOTAL/V_TOTAL.
Sub-module vga_axis_counter (one instance per axis):
- Parametrised by ACTIVE/FP/SYNC/BP/POL.
- Inputs: advance and wrap-enable.
- Outputs: count, blnk, sync, wrap.
- Horizontal instance advances on pix_ce. Vertical instance advances on the horizontal wrap.

Test Plan:
- Small mode (H 8/2/3/3 -> 16, V 4/1/2/1 -> 8), pix_ce=1, 3 frames -> hcount cycles 0..15; vcount 0..7 with each value held 16 clks; hsync=1 exactly for hcount 10..12; vsync=1 for vcount 5..6; de=1 for 32 clks per frame; frame_cnt reaches 3.
- Last-line check, small mode -> at vcount=7 hcount runs to 15 before (0,0); frame_start pulses once per 128 clks, coincident with line_start.
- pix_ce toggling 1,0,0,1 (random 40% duty) -> counts advance only on ce clks; no strobe lasts more than one clk; frame period equals 128 ce-cycles.
- HSYNC_POL=0, VSYNC_POL=0 -> after reset hsync=vsync=1; low exactly at hcount 10..12 and vcount 5..6.
- rst_n=0 for one clk at (hcount 9, vcount 3), after frame_cnt=2 -> next cycle all reset values, frame_cnt=0, no frame_start; counting resumes from 0.
- XGA defaults -> hsync width 136 clks starting at hcount 1048; line 1344 clks; frame 1344*806 clks; FRAME_W=8 wraps 255 -> 0.

Source files
------------

// File: rtl/vga_pkg.sv
// vga_pkg: shared definitions for the VGA timing slice.
//   - Standard mode constants (XGA 1024x768, SVGA 800x600).
//   - axis_total(): one axis' total length (active + porches + sync).
package vga_pkg;

  // XGA 1024x768 @ 60 Hz (65 MHz pixel clock), positive syncs on this board.
  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;
  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;
  localparam bit XGA_HSYNC_POL = 1'b1;
  localparam bit XGA_VSYNC_POL = 1'b1;

  // SVGA 800x600 @ 60 Hz (40 MHz pixel clock).
  localparam int SVGA_H_ACTIVE = 800;
  localparam int SVGA_H_FP     = 40;
  localparam int SVGA_H_SYNC   = 128;
  localparam int SVGA_H_BP     = 88;
  localparam int SVGA_V_ACTIVE = 600;
  localparam int SVGA_V_FP     = 1;
  localparam int SVGA_V_SYNC   = 4;
  localparam int SVGA_V_BP     = 23;
  localparam bit SVGA_HSYNC_POL = 1'b1;
  localparam bit SVGA_VSYNC_POL = 1'b1;

  // Total length of one axis (pixels per line or lines per frame).
  function automatic int axis_total(input int active, input int fp,
                                    input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// vga_axis_counter: one axis (horizontal or vertical) of the VGA raster.
//   clk_i      system clock
//   rst_ni     synchronous active-low reset
//   advance_i  step the count by one position this clock
//   wrap_en_i  allow the count to return to 0 after the last position;
//              when low the count parks at the last position
//   count_o    registered position, 0..TOTAL-1
//   blnk_o     registered, high when count_o >= ACTIVE
//   sync_o     registered, POL level while count_o is inside the sync pulse
//   wrap_o     combinational, high on the clock whose edge returns count to 0
//   blnk_d_o   combinational, the value blnk_o takes at the next edge
// All registered outputs are decoded from the next-state count, so they line
// up with count_o in the same cycle.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACTIVE = 1024,
  parameter int FP     = 24,
  parameter int SYNC   = 136,
  parameter int BP     = 160,
  parameter bit POL    = 1'b1,
  parameter int CNT_W  = 11
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             advance_i,
  input  logic             wrap_en_i,
  output logic [CNT_W-1:0] count_o,
  output logic             blnk_o,
  output logic             sync_o,
  output logic             wrap_o,
  output logic             blnk_d_o
);

  localparam int TOTAL = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] LAST     = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] ACT      = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] SYNC_BEG = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACTIVE + FP + SYNC);

  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] dec_pos;
  logic             blnk_q, blnk_d;
  logic             sync_q, sync_d;
  logic             at_last;

  // Anything at or beyond the last position is treated as the last position,
  // so a corrupted count recovers on its next advance.
  assign at_last = (count_q >= LAST);
  assign wrap_o  = advance_i && wrap_en_i && at_last;

  always_comb begin
    count_d = count_q;
    if (advance_i) begin
      if (at_last) begin
        count_d = wrap_en_i ? '0 : LAST;
      end else begin
        count_d = count_q + 1'b1;
      end
    end
  end

  // Decode from the next-state count; out-of-range values decode as LAST.
  always_comb begin
    dec_pos = (count_d > LAST) ? LAST : count_d;
    blnk_d  = (dec_pos >= ACT);
    sync_d  = ((dec_pos >= SYNC_BEG) && (dec_pos < SYNC_END)) ? POL : ~POL;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      count_q <= '0;
      blnk_q  <= 1'b0;
      sync_q  <= ~POL;
    end else begin
      count_q <= count_d;
      blnk_q  <= blnk_d;
      sync_q  <= sync_d;
    end
  end

  assign count_o  = count_q;
  assign blnk_o   = blnk_q;
  assign sync_o   = sync_q;
  assign blnk_d_o = blnk_d;

endmodule

// File: rtl/vga_timing_param.sv
// vga_timing_param: parametrised VGA raster timing generator.
//   clk_i          system clock
//   rst_ni         synchronous active-low reset (wins over pix_ce_i)
//   pix_ce_i       pixel clock enable; the raster advances only when high
//   hcount_o       horizontal position 0..H_TOTAL-1
//   vcount_o       vertical position 0..V_TOTAL-1
//   hblnk_o        high when hcount_o >= H_ACTIVE
//   vblnk_o        high when vcount_o >= V_ACTIVE
//   hsync_o        HSYNC_POL level inside the horizontal sync pulse
//   vsync_o        VSYNC_POL level inside the vertical sync pulse
//   de_o           display enable, !hblnk_o && !vblnk_o
//   line_start_o   one-clock strobe in the first cycle hcount_o shows 0 after a wrap
//   frame_start_o  one-clock strobe in the first cycle of (0,0) after a frame wrap
//   frame_cnt_o    completed-frame counter, modulo 2^FRAME_W
// Every output is a flop; all are mutually aligned cycle by cycle.
module vga_timing_param
  import vga_pkg::*;
#(
  parameter int H_ACTIVE  = XGA_H_ACTIVE,
  parameter int H_FP      = XGA_H_FP,
  parameter int H_SYNC    = XGA_H_SYNC,
  parameter int H_BP      = XGA_H_BP,
  parameter int V_ACTIVE  = XGA_V_ACTIVE,
  parameter int V_FP      = XGA_V_FP,
  parameter int V_SYNC    = XGA_V_SYNC,
  parameter int V_BP      = XGA_V_BP,
  parameter bit HSYNC_POL = XGA_HSYNC_POL,
  parameter bit VSYNC_POL = XGA_VSYNC_POL,
  parameter int CNT_W     = 11,
  parameter int FRAME_W   = 8
) (
  input  logic               clk_i,
  input  logic               rst_ni,
  input  logic               pix_ce_i,
  output logic [CNT_W-1:0]   hcount_o,
  output logic [CNT_W-1:0]   vcount_o,
  output logic               hblnk_o,
  output logic               vblnk_o,
  output logic               hsync_o,
  output logic               vsync_o,
  output logic               de_o,
  output logic               line_start_o,
  output logic               frame_start_o,
  output logic [FRAME_W-1:0] frame_cnt_o
);

  localparam int H_TOTAL = axis_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
  localparam int V_TOTAL = axis_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

  if ((64'(H_TOTAL) > (64'(1) << CNT_W)) || (64'(V_TOTAL) > (64'(1) << CNT_W))) begin : g_bad_cnt_w
    $error("vga_timing_param: CNT_W too narrow for H_TOTAL/V_TOTAL");
  end
  if ((H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
      (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_bad_timing
    $error("vga_timing_param: every active/porch/sync length must be >= 1");
  end

  logic h_wrap, v_wrap, h_blnk_d, v_blnk_d;

  vga_axis_counter #(
    .ACTIVE (H_ACTIVE),
    .FP     (H_FP),
    .SYNC   (H_SYNC),
    .BP     (H_BP),
    .POL    (HSYNC_POL),
    .CNT_W  (CNT_W)
  ) u_h_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance_i (pix_ce_i),
    .wrap_en_i (1'b1),
    .count_o   (hcount_o),
    .blnk_o    (hblnk_o),
    .sync_o    (hsync_o),
    .wrap_o    (h_wrap),
    .blnk_d_o  (h_blnk_d)
  );

  // The vertical axis steps once per completed line, so the last line of a
  // frame always runs its full length before (0,0).
  vga_axis_counter #(
    .ACTIVE (V_ACTIVE),
    .FP     (V_FP),
    .SYNC   (V_SYNC),
    .BP     (V_BP),
    .POL    (VSYNC_POL),
    .CNT_W  (CNT_W)
  ) u_v_axis (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .advance_i (h_wrap),
    .wrap_en_i (1'b1),
    .count_o   (vcount_o),
    .blnk_o    (vblnk_o),
    .sync_o    (vsync_o),
    .wrap_o    (v_wrap),
    .blnk_d_o  (v_blnk_d)
  );

  logic               de_q, line_start_q, frame_start_q;
  logic [FRAME_W-1:0] frame_cnt_q;

  // v_wrap already implies h_wrap (the vertical axis only advances on it).
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      de_q          <= 1'b1;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      frame_cnt_q   <= '0;
    end else begin
      de_q          <= ~h_blnk_d & ~v_blnk_d;
      line_start_q  <= h_wrap;
      frame_start_q <= v_wrap;
      if (v_wrap) begin
        frame_cnt_q <= frame_cnt_q + 1'b1;
      end
    end
  end

  assign de_o          = de_q;
  assign line_start_o  = line_start_q;
  assign frame_start_o = frame_start_q;
  assign frame_cnt_o   = frame_cnt_q;

endmodule

// File: tb/tb_vga_timing_param.sv
// Bench for vga_timing_param: three instances share clock, reset and pixel
// enable -- small mode (16x8) with positive syncs, the same with negative
// syncs, and XGA defaults. A pixel-count model predicts every output of every
// instance each clock; a directed table and hand sequences cover corners.
module tb_vga_timing_param;

  typedef struct packed {
    logic [10:0] h;
    logic [10:0] v;
    logic        hb;
    logic        vb;
    logic        hs;
    logic        vs;
    logic        de;
    logic        ls;
    logic        fs;
    logic [7:0]  fc;
  } out_t;

  typedef struct {
    bit do_rst;
    int ncyc;
    int h;
    int v;
    int fc;
    bit hs;
    bit de;
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic pix_ce = 1'b0;
  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;

  // ---------------- DUTs ----------------
  logic [10:0] a_h, a_v, b_h, b_v, c_h, c_v;
  logic a_hb, a_vb, a_hs, a_vs, a_de, a_ls, a_fs;
  logic b_hb, b_vb, b_hs, b_vs, b_de, b_ls, b_fs;
  logic c_hb, c_vb, c_hs, c_vs, c_de, c_ls, c_fs;
  logic [7:0] a_fc, b_fc, c_fc;

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b1), .VSYNC_POL(1'b1), .CNT_W(11), .FRAME_W(8)
  ) u_a (
    .clk_i(clk), .rst_ni(rst_n), .pix_ce_i(pix_ce),
    .hcount_o(a_h), .vcount_o(a_v), .hblnk_o(a_hb), .vblnk_o(a_vb),
    .hsync_o(a_hs), .vsync_o(a_vs), .de_o(a_de), .line_start_o(a_ls),
    .frame_start_o(a_fs), .frame_cnt_o(a_fc)
  );

  vga_timing_param #(
    .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
    .V_ACTIVE(4), .V_FP(1), .V_SYNC(2), .V_BP(1),
    .HSYNC_POL(1'b0), .VSYNC_POL(1'b0), .CNT_W(11), .FRAME_W(8)
  ) u_b (
    .clk_i(clk), .rst_ni(rst_n), .pix_ce_i(pix_ce),
    .hcount_o(b_h), .vcount_o(b_v), .hblnk_o(b_hb), .vblnk_o(b_vb),
    .hsync_o(b_hs), .vsync_o(b_vs), .de_o(b_de), .line_start_o(b_ls),
    .frame_start_o(b_fs), .frame_cnt_o(b_fc)
  );

  vga_timing_param u_c (
    .clk_i(clk), .rst_ni(rst_n), .pix_ce_i(pix_ce),
    .hcount_o(c_h), .vcount_o(c_v), .hblnk_o(c_hb), .vblnk_o(c_vb),
    .hsync_o(c_hs), .vsync_o(c_vs), .de_o(c_de), .line_start_o(c_ls),
    .frame_start_o(c_fs), .frame_cnt_o(c_fc)
  );

  // ---------------- reference model ----------------
  // k = pixel-enabled clocks since reset; stb = this edge advanced the raster.
  longint k   = 0;
  bit     stb = 1'b0;

  function automatic out_t model(input longint kk, input bit st,
                                 input int ha, input int hf, input int hs, input int hbp,
                                 input int va, input int vf, input int vs, input int vbp,
                                 input bit hp, input bit vp);
    out_t o;
    longint ht = longint'(ha + hf + hs + hbp);
    longint vt = longint'(va + vf + vs + vbp);
    longint h  = kk % ht;
    longint v  = (kk / ht) % vt;
    o.h  = 11'(h);
    o.v  = 11'(v);
    o.hb = (h >= ha);
    o.vb = (v >= va);
    o.hs = (h >= ha + hf && h < ha + hf + hs) ? hp : !hp;
    o.vs = (v >= va + vf && v < va + vf + vs) ? vp : !vp;
    o.de = !o.hb && !o.vb;
    o.ls = st && (h == 0);
    o.fs = st && (h == 0) && (v == 0);
    o.fc = 8'((kk / (ht * vt)) % 256);
    return o;
  endfunction

  // ---------------- scoreboard ----------------
  task automatic cmp_out(input string name, input out_t got, input out_t exp);
    n_cmp++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s k=%0d actual h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d required h=%0d v=%0d hb=%b vb=%b hs=%b vs=%b de=%b ls=%b fs=%b fc=%0d",
               name, k, got.h, got.v, got.hb, got.vb, got.hs, got.vs, got.de, got.ls, got.fs, got.fc,
               exp.h, exp.v, exp.hb, exp.vb, exp.hs, exp.vs, exp.de, exp.ls, exp.fs, exp.fc);
    end
  endtask

  task automatic chk(input string name, input int actual, input int required);
    n_cmp++;
    if (actual != required) begin
      n_fail++;
      $display("FAIL %s actual=%0d required=%0d (k=%0d)", name, actual, required, k);
    end
  endtask

  task automatic check_all();
    cmp_out("small_pos", {a_h, a_v, a_hb, a_vb, a_hs, a_vs, a_de, a_ls, a_fs, a_fc},
            model(k, stb, 8, 2, 3, 3, 4, 1, 2, 1, 1'b1, 1'b1));
    cmp_out("small_neg", {b_h, b_v, b_hb, b_vb, b_hs, b_vs, b_de, b_ls, b_fs, b_fc},
            model(k, stb, 8, 2, 3, 3, 4, 1, 2, 1, 1'b0, 1'b0));
    cmp_out("xga", {c_h, c_v, c_hb, c_vb, c_hs, c_vs, c_de, c_ls, c_fs, c_fc},
            model(k, stb, 1024, 24, 136, 160, 768, 3, 6, 29, 1'b1, 1'b1));
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input bit rst, input bit ce);
    rst_n  = !rst;
    pix_ce = ce;
    @(posedge clk);
    if (rst) begin
      k   = 0;
      stb = 1'b0;
    end else if (ce) begin
      k++;
      stb = 1'b1;
    end else begin
      stb = 1'b0;
    end
    #1;
    check_all();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle(1'b0, 1'b1);
  endtask

  // ---------------- test ----------------
  vec_t vecs[8];

  initial begin
    // Expected small-mode position after each step (hand-computed, 16x8 raster).
    vecs[0] = '{do_rst:1, ncyc:0,   h:0,  v:0, fc:0, hs:0, de:1};
    vecs[1] = '{do_rst:0, ncyc:10,  h:10, v:0, fc:0, hs:1, de:0};
    vecs[2] = '{do_rst:0, ncyc:2,   h:12, v:0, fc:0, hs:1, de:0};
    vecs[3] = '{do_rst:0, ncyc:1,   h:13, v:0, fc:0, hs:0, de:0};
    vecs[4] = '{do_rst:0, ncyc:3,   h:0,  v:1, fc:0, hs:0, de:1};
    vecs[5] = '{do_rst:0, ncyc:71,  h:7,  v:5, fc:0, hs:0, de:0};
    vecs[6] = '{do_rst:0, ncyc:297, h:0,  v:0, fc:3, hs:0, de:1};
    vecs[7] = '{do_rst:1, ncyc:313, h:9,  v:3, fc:2, hs:0, de:0};

    cycle(1'b1, 1'b0);
    cycle(1'b1, 1'b1);

    for (int i = 0; i < 8; i++) begin
      if (vecs[i].do_rst) cycle(1'b1, 1'b1);
      run(vecs[i].ncyc);
      chk($sformatf("vec%0d_h", i),  int'(a_h),  vecs[i].h);
      chk($sformatf("vec%0d_v", i),  int'(a_v),  vecs[i].v);
      chk($sformatf("vec%0d_fc", i), int'(a_fc), vecs[i].fc);
      chk($sformatf("vec%0d_hs", i), int'(a_hs), int'(vecs[i].hs));
      chk($sformatf("vec%0d_de", i), int'(a_de), int'(vecs[i].de));
    end

    // Mid-frame reset at (9,3) with two frames done: immediate abort, no strobe.
    cycle(1'b1, 1'b1);
    chk("midrst_h", int'(a_h), 0);
    chk("midrst_v", int'(a_v), 0);
    chk("midrst_fc", int'(a_fc), 0);
    chk("midrst_fs", int'(a_fs), 0);
    chk("midrst_ls", int'(a_ls), 0);
    chk("midrst_hb", int'(a_hb), 0);
    chk("midrst_vb", int'(a_vb), 0);
    chk("midrst_de", int'(a_de), 1);
    chk("midrst_neg_hs", int'(b_hs), 1);
    chk("midrst_neg_vs", int'(b_vs), 1);
    cycle(1'b0, 1'b1);
    chk("resume_h", int'(a_h), 1);

    // Last line runs full length, then frame and line strobes coincide.
    cycle(1'b1, 1'b1);
    run(127);
    chk("lastline_h", int'(a_h), 15);
    chk("lastline_v", int'(a_v), 7);
    chk("lastline_fs_pre", int'(a_fs), 0);
    cycle(1'b0, 1'b1);
    chk("frame_wrap_h", int'(a_h), 0);
    chk("frame_wrap_v", int'(a_v), 0);
    chk("frame_wrap_fs", int'(a_fs), 1);
    chk("frame_wrap_ls", int'(a_ls), 1);
    chk("frame_wrap_fc", int'(a_fc), 1);

    // Pixel enable held low: everything holds, strobes drop.
    cycle(1'b0, 1'b0);
    chk("ce_hold_h", int'(a_h), 0);
    chk("ce_hold_fs", int'(a_fs), 0);
    chk("ce_hold_fc", int'(a_fc), 1);

    // Random pixel enable (~40 % duty), model checks every clock.
    cycle(1'b1, 1'b1);
    for (int i = 0; i < 3000; i++) cycle(1'b0, ($urandom_range(0, 99) < 40));

    // XGA horizontal sync: 136 clocks starting at hcount 1048, line of 1344.
    cycle(1'b1, 1'b1);
    run(1047);
    chk("xga_hs_before", int'(c_hs), 0);
    run(1);
    chk("xga_hs_start_h", int'(c_h), 1048);
    chk("xga_hs_start", int'(c_hs), 1);
    run(135);
    chk("xga_hs_last", int'(c_hs), 1);
    run(1);
    chk("xga_hs_end", int'(c_hs), 0);
    run(1344 - 1184);
    chk("xga_line_h", int'(c_h), 0);
    chk("xga_line_v", int'(c_v), 1);
    chk("xga_line_ls", int'(c_ls), 1);

    // frame_cnt wraps 255 -> 0 (small mode, 256 frames of 128 clocks).
    cycle(1'b1, 1'b1);
    run(256 * 128 - 1);
    chk("fc_255", int'(a_fc), 255);
    run(1);
    chk("fc_wrap", int'(a_fc), 0);
    chk("fc_wrap_fs", int'(a_fs), 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
